// File: rtl/mem_ctrl.sv
// mem_ctrl: IJVM RAM initiator for the word (MAR/MDR) and byte-fetch (PC/MBR) channels.
// Define MEMCTL_ADDR_CHECK_EN to enable the sticky address-range check.
module mem_ctrl #(
   parameter int WORD_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 32,
   parameter int RAM_DEPTH     = 128
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rd_req,
   input  logic                      wr_req,
   input  logic [ADDRESS_WIDTH-1:0]  mar,
   input  logic [4*WORD_WIDTH-1:0]   mdr_in,
   output logic [4*WORD_WIDTH-1:0]   mdr_out,
   output logic                      word_busy,
   output logic                      word_done,
   input  logic                      fetch_req,
   input  logic [ADDRESS_WIDTH-1:0]  pc,
   output logic [WORD_WIDTH-1:0]     mbr_out,
   output logic                      mbr_valid,
   output logic                      fetch_busy,
   output logic                      addr_err,
   output logic [ADDRESS_WIDTH-1:0]  ram_word_address,
   inout  wire  [4*WORD_WIDTH-1:0]   ram_word_data,
   output logic                      ram_read,
   output logic                      ram_write,
   output logic [ADDRESS_WIDTH-1:0]  ram_byte_address,
   input  logic [WORD_WIDTH-1:0]     ram_byte_data,
   output logic                      ram_fetch
);
   localparam int WW = WORD_WIDTH;
   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = 4 * WORD_WIDTH;
`ifdef MEMCTL_ADDR_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, RD1, RD2, WR} state_t;
   state_t state_q, state_d;
   logic word_sq_q, word_sq_d, word_done_q, word_done_d;
   logic ram_read_q, ram_read_d, ram_write_q, ram_write_d;
   logic [AW-1:0] waddr_q, waddr_d, baddr_q, baddr_d;
   logic [DW-1:0] wdata_q, wdata_d, mdr_q, mdr_d;
   logic [WW-1:0] mbr_q, mbr_d;
   logic f1_q, f1_d, f2_q, f2_d, fsq_q, fsq_d;
   logic ram_fetch_q, ram_fetch_d, mbr_valid_q, mbr_valid_d, err_q, err_d;
   logic word_acc, fetch_acc, word_bad, fetch_bad;
   assign word_acc  = state_q == IDLE && (rd_req || wr_req);
   assign fetch_acc = fetch_req && !fetch_busy;
   assign word_bad  = CHECK && ((mar << 2) + AW'(3) >= AW'(RAM_DEPTH));
   assign fetch_bad = CHECK && (pc >= AW'(RAM_DEPTH));
   // Squashed requests keep their normal timing but never raise a RAM strobe.
   always_comb begin
      state_d     = state_q;
      word_sq_d   = word_sq_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      mdr_d       = mdr_q;
      word_done_d = 1'b0;
      if (word_acc) begin
         state_d   = wr_req ? WR : RD1;
         word_sq_d = word_bad;
         waddr_d   = mar << 2;
         wdata_d   = mdr_in;
      end else if (state_q == RD1) begin
         state_d = RD2;
      end else if (state_q != IDLE) begin
         state_d     = IDLE;
         word_done_d = 1'b1;
         mdr_d       = (state_q == RD2 && !word_sq_q) ? ram_word_data : mdr_q;
      end
      ram_read_d  = !word_sq_d && (state_d == RD1 || state_d == RD2);
      ram_write_d = !word_sq_d && state_d == WR;
      f1_d        = fetch_acc;
      f2_d        = f1_q;
      fsq_d       = fetch_acc ? fetch_bad : fsq_q;
      baddr_d     = fetch_acc ? pc : baddr_q;
      ram_fetch_d = fetch_acc && !fetch_bad;
      mbr_valid_d = f2_q;
      mbr_d       = (f2_q && !fsq_q) ? ram_byte_data : mbr_q;
      err_d       = err_q | (word_acc & word_bad) | (fetch_acc & fetch_bad);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         word_sq_q   <= 1'b0;
         word_done_q <= 1'b0;
         ram_read_q  <= 1'b0;
         ram_write_q <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         mdr_q       <= '0;
         baddr_q     <= '0;
         mbr_q       <= '0;
         f1_q        <= 1'b0;
         f2_q        <= 1'b0;
         fsq_q       <= 1'b0;
         ram_fetch_q <= 1'b0;
         mbr_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_sq_q   <= word_sq_d;
         word_done_q <= word_done_d;
         ram_read_q  <= ram_read_d;
         ram_write_q <= ram_write_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         mdr_q       <= mdr_d;
         baddr_q     <= baddr_d;
         mbr_q       <= mbr_d;
         f1_q        <= f1_d;
         f2_q        <= f2_d;
         fsq_q       <= fsq_d;
         ram_fetch_q <= ram_fetch_d;
         mbr_valid_q <= mbr_valid_d;
         err_q       <= err_d;
      end
   end
   assign mdr_out          = mdr_q;
   assign word_busy        = state_q != IDLE;
   assign word_done        = word_done_q;
   assign mbr_out          = mbr_q;
   assign mbr_valid        = mbr_valid_q;
   assign fetch_busy       = f1_q | f2_q;
   assign addr_err         = err_q;
   assign ram_word_address = waddr_q;
   assign ram_word_data    = ram_write_q ? wdata_q : 'z;
   assign ram_read         = ram_read_q;
   assign ram_write        = ram_write_q;
   assign ram_byte_address = baddr_q;
   assign ram_fetch        = ram_fetch_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized bench for mem_ctrl with a byte-array RAM and a shadow memory model.
// Define MEMCTL_ADDR_CHECK_EN to also exercise the address-range check.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic reset, rd_req, wr_req, fetch_req, fill;
   logic [31:0] mar, mdr_in, pc, mdr_out, ram_word_address, ram_byte_address;
   wire  [31:0] ram_word_data;
   logic [7:0] mbr_out, ram_byte_data;
   logic word_busy, word_done, mbr_valid, fetch_busy, addr_err, ram_read, ram_write, ram_fetch;
   logic [7:0] mem [128];
   logic [7:0] sh [128];
   logic [31:0] rd_reg;
   logic rd_v = 1'b0;
   logic [31:0] zz = 'z;
   logic [31:0] last_mdr = '0;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .mar(mar), .mdr_in(mdr_in),
      .mdr_out(mdr_out), .word_busy(word_busy), .word_done(word_done), .fetch_req(fetch_req),
      .pc(pc), .mbr_out(mbr_out), .mbr_valid(mbr_valid), .fetch_busy(fetch_busy),
      .addr_err(addr_err), .ram_word_address(ram_word_address), .ram_word_data(ram_word_data),
      .ram_read(ram_read), .ram_write(ram_write), .ram_byte_address(ram_byte_address),
      .ram_byte_data(ram_byte_data), .ram_fetch(ram_fetch)
   );

   function automatic logic [7:0] pat(int i);
      return 8'(i * 37 + 11);
   endfunction

   // RAM: little-endian bytes, word read registered at the first ram_read edge.
   always @(posedge clk) begin
      if (fill) for (int i = 0; i < 128; i++) mem[i] <= pat(i);
      if (ram_write) for (int i = 0; i < 4; i++) mem[ram_word_address[6:0] + 7'(i)] <= ram_word_data[8*i +: 8];
      if (ram_read) rd_reg <= {mem[ram_word_address[6:0] + 7'd3], mem[ram_word_address[6:0] + 7'd2],
                               mem[ram_word_address[6:0] + 7'd1], mem[ram_word_address[6:0]]};
      rd_v <= ram_read;
      if (ram_fetch) ram_byte_data <= mem[ram_byte_address[6:0]];
   end
   assign ram_word_data = (rd_v && ram_read) ? rd_reg : 'z;

   function automatic logic [31:0] sh_word(logic [31:0] a);
      logic [6:0] b;
      b = 7'(a << 2);
      return {sh[b + 7'd3], sh[b + 7'd2], sh[b + 7'd1], sh[b]};
   endfunction

   task automatic sh_write(input logic [31:0] a, input logic [31:0] d);
      logic [6:0] b;
      b = 7'(a << 2);
      for (int i = 0; i < 4; i++) sh[b + 7'(i)] = d[8*i +: 8];
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One word request and/or fetch; watches four cycles after acceptance.
   task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                      input bit f, input logic [31:0] p);
      logic [31:0] exp_w, got_w;
      logic [7:0] exp_b, got_b;
      logic [3:0] fb;
      int dn, dn_at, mv, mv_at, rdc, wrc, both, bus_bad;
      dn = 0; dn_at = 0; mv = 0; mv_at = 0; rdc = 0; wrc = 0; both = 0; bus_bad = 0;
      got_w = '0; got_b = '0; fb = '0;
      exp_w = sh_word(a);
      exp_b = sh[p[6:0]];
      wr_req = wr; rd_req = rd; mar = a; mdr_in = d; fetch_req = f; pc = p;
      tick;
      wr_req = 0; rd_req = 0; fetch_req = 0;
      if (wr) sh_write(a, d);
      for (int s = 1; s <= 4; s++) begin
         if (word_done) begin dn++; dn_at = s; got_w = mdr_out; end
         if (mbr_valid) begin mv++; mv_at = s; got_b = mbr_out; end
         if (ram_read) rdc++;
         if (ram_write) wrc++;
         if (ram_read && ram_write) both++;
         if (!ram_read && !ram_write && ram_word_data !== zz) bus_bad++;
         if (ram_write && ram_word_data !== d) bus_bad++;
         fb[4-s] = fetch_busy;
         if (s == 1 && (wr || rd)) chk("word_addr", ram_word_address, a << 2);
         if (s == 1 && f) chk("byte_addr", ram_byte_address, p);
         tick;
      end
      chk("rw_excl", both, 0);
      chk("bus", bus_bad, 0);
      if (wr || rd) begin
         chk("done_cnt", dn, 1);
         chk("done_at", dn_at, wr ? 2 : 3);
         chk("read_cycles", rdc, wr ? 0 : 2);
         chk("write_cycles", wrc, wr ? 1 : 0);
      end
      if (rd && !wr) begin
         chk("mdr", got_w, exp_w);
         last_mdr = exp_w;
      end
      if (f) begin
         chk("mv_cnt", mv, 1);
         chk("mv_at", mv_at, 3);
         chk("mbr", got_b, exp_b);
         chk("fetch_busy", fb, 4'b1100);
      end
   endtask

   initial begin
      int n_rd, n_dn;
      bit w, r, f;
      int op;
      reset = 1; wr_req = 1; rd_req = 0; fetch_req = 0; fill = 1;
      mar = 0; mdr_in = 32'h1234_5678; pc = 0;
      for (int i = 0; i < 128; i++) sh[i] = pat(i);
      tick;
      fill = 0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_strobes", {ram_read, ram_write, ram_fetch}, 3'b000);
         chk("rst_bus", ram_word_data, zz);
         chk("rst_flags", {word_busy, fetch_busy, word_done, mbr_valid}, 4'b0000);
         tick;
      end
      chk("rst_out", {mdr_out, mbr_out, addr_err}, 41'd0);
      reset = 0; wr_req = 0;
      tick;
      // write then back-to-back read in the done cycle
      wr_req = 1; mar = 2; mdr_in = 32'hDEAD_BEEF;
      tick;
      wr_req = 0;
      chk("t2_waddr", ram_word_address, 32'd8);
      chk("t2_wstrobe", {ram_read, ram_write}, 2'b01);
      chk("t2_wbus", ram_word_data, 32'hDEAD_BEEF);
      tick;
      chk("t2_wdone", word_done, 1'b1);
      sh_write(2, 32'hDEAD_BEEF);
      rd_req = 1;
      tick;
      rd_req = 0;
      chk("t2_raddr", ram_word_address, 32'd8);
      chk("t2_rstrobe", {ram_read, ram_write}, 2'b10);
      tick;
      chk("t2_rdone_early", word_done, 1'b0);
      tick;
      chk("t2_rdone", word_done, 1'b1);
      chk("t2_mdr", mdr_out, 32'hDEAD_BEEF);
      tick;
      txn(1, 1, 1, 32'h0000_00AA, 0, 0);
      txn(0, 1, 2, 0, 1, 8);
      chk("t4_mbr", mbr_out, 8'hEF);
      chk("t4_mdr", mdr_out, 32'hDEAD_BEEF);
      // reset during RD2
      rd_req = 1; mar = 2;
      tick;
      rd_req = 0;
      tick;
      chk("t5_in_rd2", {word_busy, ram_read}, 2'b11);
      reset = 1;
      tick;
      chk("t5_abort", {word_done, word_busy, ram_read}, 3'b000);
      tick;
      chk("t5_no_done", word_done, 1'b0);
      reset = 0;
      tick;
      txn(0, 1, 2, 0, 0, 0);
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         w = op >= 2;
         r = op[0];
         f = (op == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         txn(w, r, $urandom_range(0, 31), $urandom, f, $urandom_range(0, 127));
      end
`ifdef MEMCTL_ADDR_CHECK_EN
      txn(0, 0, 0, 0, 1, 127);
      chk("t6_pc127_ok", addr_err, 1'b0);
      rd_req = 1; mar = 32;
      tick;
      rd_req = 0;
      n_rd = 0; n_dn = 0;
      for (int s = 1; s <= 4; s++) begin
         n_rd += int'(ram_read);
         n_dn += int'(word_done);
         tick;
      end
      chk("t6_err", addr_err, 1'b1);
      chk("t6_no_read", n_rd, 0);
      chk("t6_done", n_dn, 1);
      chk("t6_mdr_kept", mdr_out, last_mdr);
`else
      n_rd = 0; n_dn = 0;
      txn(0, 1, 32, 0, 0, 0);
      chk("t6_no_err", addr_err, 1'b0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
